// File: rtl/updown_counter_param.sv
// updown_counter_param: bus-programmable bouncing up/down counter.
// Define UDC_STEP_EN to add the STEP register (addr 4); otherwise the step is fixed at 1.
module updown_counter_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             ncs_in,
    input  logic             nwr_in,
    input  logic             nrd_in,
    input  logic [2:0]       addr_in,
    input  logic [WIDTH-1:0] din_in,
    output logic [WIDTH-1:0] dout_out,
    input  logic             start_in,
    input  logic             hold_in,
    output logic [WIDTH-1:0] count_out,
    output logic             dir_out,
    output logic             err_out,
    output logic             ec_out,
    output logic             busy_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
    state_t state;
    logic [WIDTH-1:0] plr, ulr, llr, ccr, step, hits, hits_n, rd_data, next;
    logic [WIDTH:0] sum_up, diff;
    logic start_q1, start_q2, start_edge, illegal, hit, wr, rd;
`ifdef UDC_STEP_EN
    logic [WIDTH-1:0] step_r;
    assign step = step_r;
    assign illegal = llr >= ulr || plr < llr || plr > ulr || step == '0;
`else
    assign step = WIDTH'(1);
    assign illegal = llr >= ulr || plr < llr || plr > ulr;
`endif
    assign wr = !ncs_in && !nwr_in;
    assign rd = !ncs_in && nwr_in && !nrd_in;
    assign start_edge = start_q1 && !start_q2;
    assign busy_out = state == RUN;
    assign hits_n = hits + WIDTH'(1);
    // Extra bit keeps the sum/difference from wrapping before clamping to a limit
    assign sum_up = {1'b0, count_out} + {1'b0, step};
    assign diff = {1'b0, count_out} - {1'b0, step};
    assign next = dir_out ? (sum_up >= {1'b0, ulr} ? ulr : sum_up[WIDTH-1:0])
                          : ((diff[WIDTH] || diff[WIDTH-1:0] <= llr) ? llr : diff[WIDTH-1:0]);
    assign hit = next == (dir_out ? ulr : llr);
    always_comb begin
        rd_data = '0;
        case (addr_in)
            3'd0: rd_data = plr;
            3'd1: rd_data = ulr;
            3'd2: rd_data = llr;
            3'd3: rd_data = ccr;
`ifdef UDC_STEP_EN
            3'd4: rd_data = step_r;
`endif
            3'd5: rd_data = count_out;
            3'd6: rd_data = WIDTH'({busy_out, ec_out, err_out, dir_out});
            default: rd_data = '0;
        endcase
    end
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
            plr <= '0;
            ulr <= '1;
            llr <= '0;
            ccr <= '0;
`ifdef UDC_STEP_EN
            step_r <= WIDTH'(1);
`endif
            hits <= '0;
            count_out <= '0;
            dir_out <= 1'b1;
            err_out <= 1'b0;
            ec_out <= 1'b0;
            dout_out <= '0;
            start_q1 <= 1'b0;
            start_q2 <= 1'b0;
        end else begin
            start_q1 <= start_in;
            start_q2 <= start_q1;
            if (rd) dout_out <= rd_data;
            if (wr && !busy_out) begin
                case (addr_in)
                    3'd0: plr <= din_in;
                    3'd1: ulr <= din_in;
                    3'd2: llr <= din_in;
                    3'd3: ccr <= din_in;
`ifdef UDC_STEP_EN
                    3'd4: step_r <= din_in;
`endif
                    default: ;
                endcase
            end
            if (state != RUN && start_edge) begin
                err_out <= illegal;
                ec_out <= 1'b0;
                state <= illegal ? ERR : RUN;
                if (!illegal) begin
                    count_out <= plr;
                    dir_out <= plr != ulr;
                    hits <= '0;
                end
            end else if (state == RUN && !hold_in) begin
                count_out <= next;
                if (hit) begin
                    hits <= hits_n;
                    dir_out <= !dir_out;
                    if (ccr != '0 && hits_n == ccr) begin
                        state <= DONE;
                        ec_out <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed and random stimulus checked cycle-by-cycle against a
// behavioural model of the bouncing counter and its register bus.
module tb_updown_counter_param;
    localparam int W = 8;
`ifdef UDC_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif
    logic clk = 0, reset_n = 1, ncs = 1, nwr = 1, nrd = 1, start = 0, hold = 0;
    logic [2:0] addr = 0;
    logic [W-1:0] din = 0;
    logic [W-1:0] dout, count;
    logic dir, err, ec, busy;
    int n_checks = 0, n_fail = 0;
    int m_plr, m_ulr, m_llr, m_ccr, m_step, m_cnt, m_dir, m_err, m_ec, m_busy, m_hits, m_dout, m_s1, m_s2;

    updown_counter_param #(.WIDTH(W)) dut (
        .clk_in(clk), .reset_in(reset_n), .ncs_in(ncs), .nwr_in(nwr), .nrd_in(nrd),
        .addr_in(addr), .din_in(din), .dout_out(dout), .start_in(start), .hold_in(hold),
        .count_out(count), .dir_out(dir), .err_out(err), .ec_out(ec), .busy_out(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_plr = 0; m_ulr = (1 << W) - 1; m_llr = 0; m_ccr = 0; m_step = 1;
        m_cnt = 0; m_dir = 1; m_err = 0; m_ec = 0; m_busy = 0; m_hits = 0; m_dout = 0;
        m_s1 = 0; m_s2 = 0;
    endtask

    function automatic int reg_value(input int a);
        case (a)
            0: return m_plr;
            1: return m_ulr;
            2: return m_llr;
            3: return m_ccr;
            4: return STEP_EN ? m_step : 0;
            5: return m_cnt;
            6: return m_busy * 8 + m_ec * 4 + m_err * 2 + m_dir;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit start_seen, can_write;
        int nxt, lim;
        start_seen = m_s1 == 1 && m_s2 == 0;
        m_s2 = m_s1;
        m_s1 = int'(start);
        can_write = m_busy == 0;
        if (!ncs && nwr && !nrd) m_dout = reg_value(int'(addr));
        if (m_busy == 0 && start_seen) begin
            if (m_llr >= m_ulr || m_plr < m_llr || m_plr > m_ulr || m_step == 0) begin
                m_err = 1; m_ec = 0;
            end else begin
                m_cnt = m_plr; m_dir = (m_plr != m_ulr) ? 1 : 0; m_hits = 0;
                m_err = 0; m_ec = 0; m_busy = 1;
            end
        end else if (m_busy == 1 && !hold) begin
            lim = m_dir ? m_ulr : m_llr;
            nxt = m_dir ? m_cnt + m_step : m_cnt - m_step;
            if ((m_dir == 1 && nxt >= lim) || (m_dir == 0 && nxt <= lim)) begin
                m_cnt = lim;
                m_hits++;
                m_dir = 1 - m_dir;
                if (m_ccr != 0 && m_hits == m_ccr) begin
                    m_busy = 0; m_ec = 1;
                end
            end else m_cnt = nxt;
        end
        if (!ncs && !nwr && can_write) begin
            case (int'(addr))
                0: m_plr = int'(din);
                1: m_ulr = int'(din);
                2: m_llr = int'(din);
                3: m_ccr = int'(din);
                4: if (STEP_EN) m_step = int'(din);
                default: ;
            endcase
        end
    endtask

    task automatic compare();
        check("count", int'(count), m_cnt);
        check("dir", int'(dir), m_dir);
        check("err", int'(err), m_err);
        check("ec", int'(ec), m_ec);
        check("busy", int'(busy), m_busy);
        check("dout", int'(dout), m_dout);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic bus_wr(input int a, input int d);
        ncs = 0; nwr = 0; nrd = 1; addr = 3'(a); din = W'(d);
        cycle();
        ncs = 1; nwr = 1;
    endtask

    task automatic bus_rd(input int a);
        ncs = 0; nwr = 1; nrd = 0; addr = 3'(a);
        cycle();
        ncs = 1; nrd = 1;
    endtask

    task automatic do_start();
        start = 1;
        cycle();
        start = 0;
        cycle();
    endtask

    task automatic pulse_reset();
        #2 reset_n = 0;
        #1 model_reset();
        compare();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        int held;
        int seq2[8] = '{6, 7, 8, 7, 6, 5, 4, 3};
        model_reset();
        #1 reset_n = 0;
        #1 compare();
        @(negedge clk);
        reset_n = 1;
        bus_rd(1);
        check("ulr_reset_read", int'(dout), 255);

        bus_wr(0, 5); bus_wr(1, 8); bus_wr(2, 3); bus_wr(3, 2);
        do_start();
        check("bounce_first", int'(count), 5);
        check("bounce_busy", int'(busy), 1);
        foreach (seq2[i]) begin
            cycle();
            check("bounce_seq", int'(count), seq2[i]);
        end
        check("bounce_ec", int'(ec), 1);
        check("bounce_idle", int'(busy), 0);
        check("bounce_dir", int'(dir), 1);
        repeat (2) cycle();
        check("bounce_hold3", int'(count), 3);

        bus_wr(0, 10);
        do_start();
        check("illegal_err", int'(err), 1);
        check("illegal_count", int'(count), 3);
        bus_wr(0, 4);
        do_start();
        check("legal_clears_err", int'(err), 0);
        repeat (20) cycle();

        bus_wr(3, 0); bus_wr(0, 0); bus_wr(2, 0); bus_wr(1, 3);
        do_start();
        repeat (6) cycle();
        held = int'(count);
        hold = 1;
        repeat (4) cycle();
        check("hold_freeze", int'(count), held);
        hold = 0;
        repeat (5) cycle();
        bus_wr(1, 200);
        bus_rd(1);
        check("ulr_busy_write", int'(dout), 3);
        pulse_reset();
        check("reset_mid_run", int'(busy), 0);
        bus_rd(1);

`ifdef UDC_STEP_EN
        bus_wr(4, 3); bus_wr(0, 0); bus_wr(2, 0); bus_wr(1, 10); bus_wr(3, 1);
        do_start();
        check("step_first", int'(count), 0);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("step_seq", int'(count), k < 4 ? 3 * k : 10);
        end
        check("step_ec", int'(ec), 1);
`else
        bus_wr(4, 3);
        bus_rd(4);
        check("no_step_read", int'(dout), 0);
`endif

        for (int it = 0; it < 3000; it++) begin
            int op;
            op = int'($urandom_range(0, 99));
            if (op < 2) begin
                pulse_reset();
            end else if (op < 12 && m_busy == 0) begin
                int lo, hi;
                lo = int'($urandom_range(0, 20));
                hi = lo + int'($urandom_range(0, 12));
                bus_wr(2, lo); bus_wr(1, hi);
                bus_wr(0, int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(0, 40)) : int'($urandom_range(lo, hi)));
                bus_wr(3, int'($urandom_range(0, 4)));
                bus_wr(4, int'($urandom_range(0, 5)));
                do_start();
            end else begin
                ncs = $urandom_range(0, 2) == 0 ? 1'b1 : 1'b0;
                nwr = $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1;
                nrd = 1'($urandom_range(0, 1));
                addr = 3'($urandom_range(0, 7));
                din = $urandom_range(0, 1) == 1 ? W'($urandom_range(0, 20)) : W'($urandom_range(0, 255));
                start = $urandom_range(0, 7) == 0;
                hold = $urandom_range(0, 7) == 0;
                cycle();
                ncs = 1; nwr = 1; nrd = 1; start = 0; hold = 0;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
